// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: N_REQ one-entry holding buffers sharing the register-file write port.
// Define WB_FIXED_PRIO_EN for fixed priority (lowest full index wins) instead of round-robin.

module regfile_wb_slot #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              accept,
  input  logic              issue,
  input  logic [ADDR_W-1:0] rw_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  // Writes to r0 are consumed without filling; an issue and a refill on the same edge keep it full.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (accept && (rw_in != '0)) begin
      full <= 1'b1;
      addr <= rw_in;
      data <= data_in;
    end else if (issue) begin
      full <= 1'b0;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_rw,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    rf_reg_write,
  output logic [ADDR_W-1:0]       rf_rw,
  output logic [DATA_W-1:0]       rf_busW,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
);
  logic [N_REQ-1:0]             full;
  logic [N_REQ-1:0]             gnt;
  logic [N_REQ-1:0][ADDR_W-1:0] slot_addr;
  logic [N_REQ-1:0][DATA_W-1:0] slot_data;
  logic [IDX_W-1:0]             gnt_idx;
  logic [ADDR_W-1:0]            sel_addr;
  logic [DATA_W-1:0]            sel_data;
  logic                         found;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign req_ready[g] = ~full[g] | gnt[g];

    regfile_wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .accept  (req_valid[g] & req_ready[g]),
      .issue   (gnt[g]),
      .rw_in   (req_rw[g*ADDR_W +: ADDR_W]),
      .data_in (req_data[g*DATA_W +: DATA_W]),
      .full    (full[g]),
      .addr    (slot_addr[g]),
      .data    (slot_data[g])
    );
  end

  assign busy = |full;

`ifdef WB_FIXED_PRIO_EN
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && full[i]) begin
        gnt[i]   = 1'b1;
        gnt_idx  = IDX_W'(i);
        sel_addr = slot_addr[i];
        sel_data = slot_data[i];
        found    = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last;
  int               cand;

  // Search starts one past the last winner and wraps, so every full slot waits at most N_REQ-1 issues.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    found    = 1'b0;
    cand     = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && full[i] && (cand == i)) begin
          gnt[i]   = 1'b1;
          gnt_idx  = IDX_W'(i);
          sel_addr = slot_addr[i];
          sel_data = slot_data[i];
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     last <= IDX_W'(N_REQ - 1);
    else if (found) last <= gnt_idx;
  end
`endif

  // Address/data/id hold across idle cycles; only the enable drops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rf_reg_write <= 1'b0;
      rf_rw        <= '0;
      rf_busW      <= '0;
      grant_id     <= '0;
    end else if (found) begin
      rf_reg_write <= 1'b1;
      rf_rw        <= sel_addr;
      rf_busW      <= sel_data;
      grant_id     <= gnt_idx;
    end else begin
      rf_reg_write <= 1'b0;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (reg_write / rw / busW) among N_REQ writeback sources, e.g. ALU, load unit and multiply unit.
- Each source gets a one-entry holding buffer with valid/ready handshake.
- A round-robin arbiter issues at most one write per cycle on registered outputs, which feed the register file's write inputs directly.
- Outputs change on posedge CLK, so they are stable when the register file samples on negedge CLK.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- IDX_W, 2, width of grant index; must satisfy 2**IDX_W >= N_REQ

Ports:
- CLK  input  1  system clock, all state on posedge
- RST_N  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  requester i has a write this cycle
- req_ready  output  N_REQ  requester i write accepted at this posedge if valid
- req_rw  input  N_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  N_REQ*DATA_W  write data, requester i at bits [i*DATA_W +: DATA_W]
- rf_reg_write  output  1  write enable to register file (registered)
- rf_rw  output  ADDR_W  write address to register file (registered)
- rf_busW  output  DATA_W  write data to register file (registered)
- grant_id  output  IDX_W  index of requester driving the current rf_* write (registered)
- busy  output  1  any holding buffer full

Behaviour:
- Reset (async, RST_N=0): all buffers empty; rf_reg_write=0, rf_rw=0, rf_busW=0, grant_id=0, busy=0; round-robin pointer last=N_REQ-1, so requester 0 has first priority. Writes pending when reset asserts mid-operation are discarded, and no rf_reg_write pulse occurs afterwards for them.
- Buffer i state: full[i], addr[i], data[i].
- Combinational grant vector gnt: one-hot, selects one full buffer, searching from index last+1 upward with wrap-around. gnt=0 if no buffer is full.
- req_ready[i] = ~full[i] | gnt[i]. Combinational; it does not depend on req_valid[i].
- Accept condition: req_valid[i] & req_ready[i] at posedge. Then:
  - If req_rw[i] != 0, the buffer loads addr/data and full[i]=1.
  - If req_rw[i] == 0, the write is consumed and dropped: the buffer does not fill and no rf write is issued. Register 0 is never written through this block.
- Issue at a posedge with gnt[k]=1:
  - rf_reg_write<=1, rf_rw<=addr[k], rf_busW<=data[k], grant_id<=k, last<=k.
  - full[k] clears unless the same edge accepts a new write from k (refill), in which case it stays 1 with the new contents.
- If no buffer is full: rf_reg_write<=0. rf_rw, rf_busW and grant_id hold their previous values.
- Latency: accepted at edge t, issued at earliest edge t+1, register file written at the negedge after t+1. Maximum sustained throughput is 1 write per cycle in aggregate and 1 per cycle per requester while uncontended.
- Fairness: with all buffers continuously full, grants rotate 0,1,2,0,... Each requester waits at most N_REQ-1 issue cycles.
- Ordering: writes from the same requester issue in acceptance order. Writes from different requesters to the same register issue in grant order; the later grant wins in the register file.
- busy = |full, registered with the buffers.
- No writes are lost or duplicated. Each accepted write with rw != 0 produces exactly one rf_reg_write cycle.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest full index always wins. The last pointer is not implemented, and grant_id still reports the winner.
- Undefined (default): round-robin as above.
- All ports and latency are identical in both builds.

Test Plan:
1. Reset then idle: RST_N low 2 cycles, no valid -> rf_reg_write=0, req_ready=3'b111, busy=0, grant_id=0 throughout.
2. Single write: req0 valid, rw=5'd3, data=32'hDEADBEEF for 1 cycle -> next cycle rf_reg_write=1, rf_rw=3, rf_busW=32'hDEADBEEF, grant_id=0; following cycle rf_reg_write=0.
3. Simultaneous: req0..2 valid once with rw=1,2,3, data=32'h11,32'h22,32'h33 -> three consecutive rf_reg_write cycles with grant_id 0,1,2; rw/data paired correctly; busy falls after the third. With WB_FIXED_PRIO_EN and req0 streaming continuously, req1 and req2 are starved until req0 stops.
4. Fairness under saturation: all three valid every cycle for 12 cycles -> grant_id repeats 0,1,2 and each requester gets 4 writes; req_ready never drops for the granted index.
5. r0 drop: req1 valid, rw=0, data=32'hFFFFFFFF -> accepted (req_ready=1), rf_reg_write stays 0, busy stays 0.
6. Reset mid-operation: fill all three buffers, assert RST_N low asynchronously between edges -> rf_reg_write, busy and outputs go to 0 immediately; after release, no stale write issues.
